// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        IMemWrite;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, IMemWrite, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, IMemWrite, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory; one byte/cycle plus one write bubble per word.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    FIN
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LastState = CHECK;
`else
  localparam state_t LastState = FIN;
`endif

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t      state, nextState;
  logic [7:0]  lenLo;
  logic [15:0] remaining;
  logic [1:0]  byteCnt;
  logic [31:0] addr, wdata;
  logic        byteReady, memWrite, busyC;
  logic        accept;
  logic [15:0] lenFull;
  logic        overMax;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept  = bus.byte_valid && byteReady;
  assign lenFull = {bus.byte_data, lenLo};
  assign overMax = {1'b0, lenFull} > MaxWords;

  assign bus.byte_ready = byteReady;
  assign bus.IMemWrite  = memWrite;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;
  assign busy           = busyC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    byteReady = 1'b0;
    memWrite  = 1'b0;
    busyC     = 1'b1;
    case (state)
      IDLE: begin
        busyC = 1'b0;
        if (start) nextState = LEN_LO;
      end
      LEN_LO: begin
        byteReady = 1'b1;
        if (accept) nextState = LEN_HI;
      end
      LEN_HI: begin
        byteReady = 1'b1;
        if (accept) begin
          if (lenFull == 16'd0) nextState = LastState;
          else if (overMax)     nextState = IDLE;
          else                  nextState = DATA;
        end
      end
      DATA: begin
        byteReady = 1'b1;
        if (accept && byteCnt == 2'd3) nextState = WRITE;
      end
      WRITE: begin
        memWrite  = 1'b1;
        nextState = (remaining == 16'd1) ? LastState : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byteReady = 1'b1;
        if (accept) nextState = (bus.byte_data == csum) ? FIN : IDLE;
      end
`endif
      FIN: nextState = IDLE;
      default: begin
        busyC     = 1'b0;
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lenLo     <= 8'd0;
      remaining <= 16'd0;
      byteCnt   <= 2'd0;
      addr      <= BASE_ADDR;
      wdata     <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          done      <= 1'b0;
          err       <= 1'b0;
          addr      <= BASE_ADDR;
          byteCnt   <= 2'd0;
          remaining <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum      <= 8'd0;
`endif
        end
        LEN_LO: if (accept) lenLo <= bus.byte_data;
        LEN_HI: if (accept) begin
          remaining <= lenFull;
          if (overMax) err <= 1'b1;
        end
        DATA: if (accept) begin
          // byteCnt selects the little-endian lane for this byte
          wdata[{byteCnt, 3'b000} +: 8] <= bus.byte_data;
          byteCnt <= byteCnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum    <= csum ^ bus.byte_data;
`endif
        end
        WRITE: begin
          addr      <= addr + 32'd4;
          remaining <= remaining - 16'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: if (accept && bus.byte_data != csum) err <= 1'b1;
`endif
        FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a stream-level model predicts writes, consumed bytes and done/err.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  logic [7:0]  stim[$];
  logic [31:0] expAddr[$], expData[$], obsAddr[$], obsData[$];

  always @(negedge clk) begin
    if (bus.IMemWrite) begin
      obsAddr.push_back(bus.imem_addr);
      obsData.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream-level reference: parse the byte list the way the format describes it.
  task automatic model(output bit eDone, output bit eErr, output int eUsed);
    int n;
    logic [7:0] x;
    expAddr.delete();
    expData.delete();
    eDone = 1'b0;
    eErr  = 1'b0;
    n = int'({stim[1], stim[0]});
    if (n > MAXW) begin
      eErr  = 1'b1;
      eUsed = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      expAddr.push_back(BASE + 32'(4 * i));
      expData.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
      for (int k = 0; k < 4; k++) x ^= stim[2+4*i+k];
    end
    eUsed = 2 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    eUsed++;
    if (stim[2+4*n] == x) eDone = 1'b1;
    else                  eErr  = 1'b1;
`else
    eDone = 1'b1;
`endif
  endtask

  // mode 0: valid held high, 1: valid every other cycle, 2: random valid
  task automatic run_session(input string tag, input int mode, input bit pokeStart);
    bit eDone, eErr, pend;
    int eUsed, total, cyc, nCmp;
    model(eDone, eErr, eUsed);
    total = stim.size();
    obsAddr.delete();
    obsData.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "/busy_hi"}, 32'(busy), 32'd1);
    chk({tag, "/flags_clr"}, 32'({done, err}), 32'd0);
    cyc = 0;
    while (busy && cyc < 500) begin
      bus.byte_valid = (stim.size() > 0) &&
                       (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                        (mode == 2 && $urandom_range(0, 1) == 1));
      bus.byte_data  = (stim.size() > 0) ? stim[0] : 8'h00;
      start          = pokeStart && ($urandom_range(0, 3) == 0);
      pend           = bus.byte_valid && bus.byte_ready;
      @(negedge clk);
      if (pend) void'(stim.pop_front());
      cyc++;
    end
    bus.byte_valid = 1'b0;
    start = 1'b0;
    if (cyc >= 500) chk({tag, "/timeout"}, 32'd1, 32'd0);
    chk({tag, "/busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "/done"}, 32'(done), 32'(eDone));
    chk({tag, "/err"}, 32'(err), 32'(eErr));
    chk({tag, "/consumed"}, 32'(total - stim.size()), 32'(eUsed));
    chk({tag, "/nwrites"}, 32'(obsAddr.size()), 32'(expAddr.size()));
    nCmp = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
    for (int i = 0; i < nCmp; i++) begin
      chk({tag, "/addr"}, obsAddr[i], expAddr[i]);
      chk({tag, "/data"}, obsData[i], expData[i]);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, "/idle_ready"}, 32'(bus.byte_ready), 32'd0);
      chk({tag, "/idle_flags"}, 32'({done, err}), 32'({eDone, eErr}));
    end
    bus.byte_valid = 1'b0;
    chk({tag, "/no_extra_wr"}, 32'(obsAddr.size()), 32'(expAddr.size()));
  endtask

  task automatic load_basic(input bit goodCsum);
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(goodCsum ? 8'hA0 : 8'hA1);
`else
    if (!goodCsum) stim.push_back(8'hA1);
`endif
    stim.push_back(8'h77);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "/ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "/wr"}, 32'(bus.IMemWrite), 32'd0);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    chk({tag, "/done"}, 32'(done), 32'd0);
    chk({tag, "/err"}, 32'(err), 32'd0);
    chk({tag, "/addr"}, bus.imem_addr, BASE);
    chk({tag, "/wdata"}, bus.imem_wdata, 32'd0);
  endtask

  initial begin
    int n, acc, cyc;
    bit pend;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;

    load_basic(1'b1);
    run_session("basic", 0, 1'b0);
    load_basic(1'b1);
    run_session("toggle", 1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    load_basic(1'b0);
    run_session("bad_csum", 0, 1'b0);
    stim = {8'h00, 8'h00, 8'h00, 8'h33};
`else
    stim = {8'h00, 8'h00, 8'h33};
`endif
    run_session("zero", 0, 1'b0);
    stim = {8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_session("overmax", 0, 1'b0);

    // Reset after two of four data bytes: nothing written, everything back to reset values.
    stim = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    obsAddr.delete();
    obsData.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 50) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = stim[0];
      pend = bus.byte_ready;
      @(negedge clk);
      if (pend) begin
        void'(stim.pop_front());
        acc++;
      end
      cyc++;
    end
    if (cyc >= 50) chk("midreset/timeout", 32'd1, 32'd0);
    reset_n = 1'b0;
    bus.byte_valid = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    chk("midreset/nwrites", 32'(obsAddr.size()), 32'd0);
    reset_n = 1'b1;
    load_basic(1'b1);
    run_session("after_reset", 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      stim.delete();
      n = int'($urandom_range(0, MAXW + 2));
      if (n == MAXW + 2) n = int'($urandom_range(256, 65535));
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      if (n <= MAXW + 1) begin
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          stim.push_back(8'($urandom));
          x ^= stim[stim.size() - 1];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
`endif
      end
      for (int j = 0; j < 3; j++) stim.push_back(8'($urandom));
      run_session("rand", int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
